// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Latency: accept at T, operands on alu_* at T+1, response valid from T+2; one op in flight.
// Backpressure: req readys low while busy; the response is held until the owner's rsp_ready.
module alu_share_ctrl #(
    parameter int W     = 5,
    parameter int OPW   = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [W-1:0]     rsp0_data,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [W-1:0]     rsp1_data,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [OPW-1:0]   alu_s,
    input  logic [W-1:0]     alu_y,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [OPW-1:0] op;
    } op_t;

    state_t           state;
    logic             owner;
    logic             last_grant;
    logic [W-1:0]     result;
    logic [CNT_W-1:0] ops_cnt;
    logic             rsp0_vld_q;
    logic             rsp1_vld_q;
    logic             busy_q;
    op_t              alu_op_q;

    logic             gnt0;
    logic             gnt1;
    logic             acc0;
    logic             acc1;
    logic             rsp_hs;
    op_t              req0_op_s;
    op_t              req1_op_s;
    op_t              sel_op;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        gnt0 = req0_valid & (~req1_valid | last_grant);
        gnt1 = req1_valid & (~req0_valid | ~last_grant);
    end

    assign req0_ready = (state == IDLE) & gnt0;
    assign req1_ready = (state == IDLE) & gnt1;
    assign acc0       = req0_valid & req0_ready;
    assign acc1       = req1_valid & req1_ready;

    assign req0_op_s  = '{a: req0_a, b: req0_b, op: req0_op};
    assign req1_op_s  = '{a: req1_a, b: req1_b, op: req1_op};
    assign sel_op     = acc1 ? req1_op_s : req0_op_s;

    // Only the owner's ready can complete the response.
    assign rsp_hs     = (state == RESP) & (owner ? rsp1_ready : rsp0_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            result     <= '0;
            ops_cnt    <= '0;
            rsp0_vld_q <= 1'b0;
            rsp1_vld_q <= 1'b0;
            busy_q     <= 1'b0;
            alu_op_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc0 | acc1) begin
                        alu_op_q   <= sel_op;
                        owner      <= acc1;
                        last_grant <= acc1;
                        busy_q     <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    result     <= alu_y;
                    rsp0_vld_q <= ~owner;
                    rsp1_vld_q <= owner;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_hs) begin
                        rsp0_vld_q <= 1'b0;
                        rsp1_vld_q <= 1'b0;
                        busy_q     <= 1'b0;
                        ops_cnt    <= ops_cnt + 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    rsp0_vld_q <= 1'b0;
                    rsp1_vld_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign alu_a      = alu_op_q.a;
    assign alu_b      = alu_op_q.b;
    assign alu_s      = alu_op_q.op;
    assign rsp0_valid = rsp0_vld_q;
    assign rsp1_valid = rsp1_vld_q;
    assign rsp0_data  = result;
    assign rsp1_data  = result;
    assign busy       = busy_q;
    assign ops_done   = ops_cnt;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl with an adder stub standing in for the shared ALU.
// Latency: n/a. Backpressure: exercised through held requests and delayed rsp_ready.
module tb_alu_share_ctrl;

    localparam int W     = 5;
    localparam int OPW   = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready;
    logic [W-1:0]     req0_a, req0_b;
    logic [OPW-1:0]   req0_op;
    logic             req1_valid, req1_ready;
    logic [W-1:0]     req1_a, req1_b;
    logic [OPW-1:0]   req1_op;
    logic             rsp0_valid, rsp0_ready;
    logic [W-1:0]     rsp0_data;
    logic             rsp1_valid, rsp1_ready;
    logic [W-1:0]     rsp1_data;
    logic [W-1:0]     alu_a, alu_b, alu_y;
    logic [OPW-1:0]   alu_s;
    logic             busy;
    logic [CNT_W-1:0] ops_done;

    int n_checks = 0;
    int n_fail   = 0;
    int last_w   = 1;
    int exp_ops  = 0;

    always #5 clk = ~clk;

    assign alu_y = alu_a + alu_b;

    alu_share_ctrl #(.W(W), .OPW(OPW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_y(alu_y),
        .busy(busy), .ops_done(ops_done)
    );

    typedef struct {
        int             req;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [OPW-1:0] op;
        logic [W-1:0]   exp_y;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [OPW-1:0] op);
        if (r == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end
    endtask

    // Entered at posedge+1 with the requests already driven; returns at posedge+1
    // of the first IDLE cycle after the response handshake.
    task automatic serve(input int dly, input int exp_y, output int w);
        int cnt = 0;
        int exp_w;
        int ea, eb, eop, ey;
        #1;
        exp_w = (req0_valid && req1_valid) ? (1 - last_w) : (req0_valid ? 0 : 1);
        while (!req0_ready && !req1_ready && cnt < 20) begin
            @(posedge clk); #2;
            cnt++;
        end
        w = -1;
        if (cnt >= 20) begin
            chk("accept_timeout", 1, 0);
            req0_valid = 1'b0; req1_valid = 1'b0;
            return;
        end
        chk("ready_onehot", int'(req0_ready & req1_ready), 0);
        w = req1_ready ? 1 : 0;
        chk("grant", w, exp_w);
        ea  = (w == 1) ? int'(req1_a)  : int'(req0_a);
        eb  = (w == 1) ? int'(req1_b)  : int'(req0_b);
        eop = (w == 1) ? int'(req1_op) : int'(req0_op);
        ey  = (ea + eb) % 32;
        if (exp_y >= 0) chk("table_y", ey, exp_y);
        @(posedge clk); #1;
        if (w == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        last_w = w;
        chk("exec_alu_a", int'(alu_a), ea);
        chk("exec_alu_b", int'(alu_b), eb);
        chk("exec_alu_s", int'(alu_s), eop);
        chk("exec_busy", int'(busy), 1);
        chk("exec_no_rsp", int'(rsp0_valid | rsp1_valid), 0);
        @(posedge clk); #1;
        for (int d = 0; d <= dly; d++) begin
            chk("rsp0_valid", int'(rsp0_valid), (w == 0) ? 1 : 0);
            chk("rsp1_valid", int'(rsp1_valid), (w == 1) ? 1 : 0);
            chk("rsp_data", (w == 0) ? int'(rsp0_data) : int'(rsp1_data), ey);
            chk("rsp_busy", int'(busy), 1);
            chk("rsp_no_ready", int'(req0_ready | req1_ready), 0);
            if (w == 0) begin
                rsp0_ready = (d == dly);
                rsp1_ready = 1'($urandom_range(0, 1));
            end else begin
                rsp1_ready = (d == dly);
                rsp0_ready = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
        end
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        exp_ops = (exp_ops + 1) % 256;
        chk("ops_done", int'(ops_done), exp_ops);
        chk("idle_busy", int'(busy), 0);
        chk("idle_no_rsp", int'(rsp0_valid | rsp1_valid), 0);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        last_w  = 1;
        exp_ops = 0;
    endtask

    vec_t vecs[8];

    initial begin
        int w, prev_w;
        rst = 1'b1;
        req0_valid = 0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 0; req1_a = '0; req1_b = '0; req1_op = '0;
        rsp0_ready = 0; rsp1_ready = 0;

        vecs[0] = '{0, 5'h07, 5'h03, 4'h0, 5'h0A};
        vecs[1] = '{1, 5'h01, 5'h0C, 4'h3, 5'h0D};
        vecs[2] = '{0, 5'h1F, 5'h01, 4'hF, 5'h00};
        vecs[3] = '{1, 5'h10, 5'h10, 4'h8, 5'h00};
        vecs[4] = '{0, 5'h1E, 5'h1F, 4'h5, 5'h1D};
        vecs[5] = '{1, 5'h00, 5'h00, 4'h1, 5'h00};
        vecs[6] = '{1, 5'h0A, 5'h05, 4'hA, 5'h0F};
        vecs[7] = '{0, 5'h15, 5'h13, 4'h7, 5'h08};

        // Reset state
        do_reset(2);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(req0_ready | req1_ready), 0);
        chk("rst_rsp", int'(rsp0_valid | rsp1_valid), 0);
        chk("rst_alu", int'({alu_a, alu_b, alu_s}), 0);
        chk("rst_data", int'(rsp0_data | rsp1_data), 0);
        chk("rst_ops", int'(ops_done), 0);

        // Table of single-requester ops
        for (int i = 0; i < 8; i++) begin
            set_req(vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].op);
            serve(i % 3, int'(vecs[i].exp_y), w);
            chk("table_owner", w, vecs[i].req);
        end

        // Tie after reset: req0 first and held 5 cycles while req1 waits
        do_reset(1);
        set_req(0, 5'h15, 5'h13, 4'h2);
        set_req(1, 5'h01, 5'h0C, 4'h4);
        serve(5, 8'h08, w);
        chk("tie_first", w, 0);
        serve(0, 8'h0D, w);
        chk("tie_second", w, 1);
        set_req(0, 5'h02, 5'h02, 4'h0);
        set_req(1, 5'h03, 5'h03, 4'h0);
        serve(0, 4, w);
        chk("tie_third", w, 0);
        serve(1, 6, w);

        // Reset during EXEC discards the op
        set_req(0, 5'h09, 5'h09, 4'h6);
        #1;
        chk("pre_rst_ready", int'(req0_ready), 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        chk("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        last_w = 1; exp_ops = 0;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ops", int'(ops_done), 0);
        for (int i = 0; i < 4; i++) begin
            chk("midrst_no_rsp", int'(rsp0_valid | rsp1_valid), 0);
            @(posedge clk); #1;
        end
        set_req(1, 5'h04, 5'h05, 4'h1);
        serve(0, 9, w);
        chk("post_rst_owner", w, 1);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            if (!req0_valid && $urandom_range(0, 1) == 1)
                set_req(0, 5'($urandom), 5'($urandom), 4'($urandom));
            if (!req1_valid && $urandom_range(0, 1) == 1)
                set_req(1, 5'($urandom), 5'($urandom), 4'($urandom));
            if (!req0_valid && !req1_valid)
                set_req(int'($urandom_range(0, 1)), 5'($urandom), 5'($urandom), 4'($urandom));
            serve(int'($urandom_range(0, 3)), -1, w);
        end

        // Back-to-back contention: grants alternate, counter wraps
        if (!req0_valid) set_req(0, 5'($urandom), 5'($urandom), 4'($urandom));
        if (!req1_valid) set_req(1, 5'($urandom), 5'($urandom), 4'($urandom));
        prev_w = last_w;
        for (int i = 0; i < 256; i++) begin
            serve(0, -1, w);
            chk("alternate", w, 1 - prev_w);
            prev_w = w;
            set_req(w, 5'($urandom), 5'($urandom), 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
